// File: rtl/fetch_pkg.sv
// fetch_pkg: widths and FSM state encoding shared by the SDRAM fetch and
// write-back controllers.
package fetch_pkg;

  localparam int SDRAM_AW    = 19;
  localparam int RAM_AW      = 12;
  localparam int DATA_W      = 16;
  localparam int CNT_W       = RAM_AW + 1;
  localparam int TIMEOUT_CYC = 1024;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_RAM   = 3'd1;
  localparam logic [2:0] S_LATCH    = 3'd2;
  localparam logic [2:0] S_WR_SDRAM = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = S_IDLE,
    RD_RAM   = S_RD_RAM,
    LATCH    = S_LATCH,
    WR_SDRAM = S_WR_SDRAM,
    DONE     = S_DONE
  } wbState_t;

endpackage

// File: rtl/wb_watchdog.sv
// wb_watchdog: down-counter that flags a write acknowledge which has not
// arrived within TIMEOUT_CYC cycles of the request being raised.
module wb_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] remaining;

  // Reload on a new request, count down while the request is pending.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      remaining <= LOAD_VAL;
    end else if (i_clear) begin
      remaining <= LOAD_VAL;
    end else if (i_enable && (remaining != '0)) begin
      remaining <= remaining - CW'(1);
    end
  end

  // Terminal count reached on the TIMEOUT_CYC-th pending cycle.
  assign o_expired = i_enable && (remaining == '0);

endmodule

// File: rtl/writeback_control.sv
// writeback_control: copies i_numWords words from the on-chip result RAM to
// SDRAM starting at i_baseAddr, one handshaked write at a time.
// Build option WB_TIMEOUT_EN adds an acknowledge watchdog and the o_error port.
//
// state    | meaning
// IDLE     | waiting for an accepted i_start
// RD_RAM   | RAM read of word[index] issued
// LATCH    | RAM data and SDRAM address captured
// WR_SDRAM | write request held until acknowledged
// DONE     | all words written, o_finish follows
module writeback_control
  import fetch_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [SDRAM_AW-1:0] i_baseAddr,
  input  logic [RAM_AW:0]     i_numWords,
  output logic                o_rdRam,
  output logic [RAM_AW-1:0]   o_addrToRam,
  input  logic [DATA_W-1:0]   i_dataFromRam,
  output logic                o_wrSdram,
  output logic [SDRAM_AW-1:0] o_addrToSdram,
  output logic [DATA_W-1:0]   o_dataToSdram,
  input  logic                i_sdramReady,
  output logic                o_busy,
  output logic                o_finish
`ifdef WB_TIMEOUT_EN
  ,
  output logic                o_error
`endif
);

  wbState_t            state;
  wbState_t            nextState;
  logic [SDRAM_AW-1:0] baseAddr;
  logic [CNT_W-1:0]    wordCount;
  logic [CNT_W-1:0]    index;
  logic                startAccept;
  logic                ackTaken;
  logic                lastWord;

`ifdef WB_TIMEOUT_EN
  logic wdExpired;
  logic abortTimeout;

  wb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) uWatchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (state == LATCH),
    .i_enable  (state == WR_SDRAM),
    .o_expired (wdExpired)
  );
`endif

  assign o_addrToRam = index[RAM_AW-1:0];
  assign lastWord    = (index + CNT_W'(1)) == wordCount;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode and handshake strobes. A start coinciding with the
  // o_finish pulse is dropped so back-to-back jobs need a fresh request.
  always_comb begin
    nextState   = state;
    o_rdRam     = 1'b0;
    o_wrSdram   = 1'b0;
    startAccept = 1'b0;
    ackTaken    = 1'b0;
`ifdef WB_TIMEOUT_EN
    abortTimeout = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (i_start && !o_finish) begin
          startAccept = 1'b1;
          nextState   = (i_numWords == '0) ? DONE : RD_RAM;
        end
      end
      RD_RAM: begin
        o_rdRam   = 1'b1;
        nextState = LATCH;
      end
      LATCH: begin
        nextState = WR_SDRAM;
      end
      WR_SDRAM: begin
        o_wrSdram = 1'b1;
        if (i_sdramReady) begin
          ackTaken  = 1'b1;
          nextState = lastWord ? DONE : RD_RAM;
        end
`ifdef WB_TIMEOUT_EN
        else if (wdExpired) begin
          abortTimeout = 1'b1;
          nextState    = IDLE;
        end
`endif
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Job registers, write address/data capture and status pulses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      baseAddr      <= '0;
      wordCount     <= '0;
      index         <= '0;
      o_addrToSdram <= '0;
      o_dataToSdram <= '0;
      o_busy        <= 1'b0;
      o_finish      <= 1'b0;
`ifdef WB_TIMEOUT_EN
      o_error       <= 1'b0;
`endif
    end else begin
      o_finish <= (state == DONE);
`ifdef WB_TIMEOUT_EN
      o_error  <= abortTimeout;
`endif
      if (startAccept) begin
        baseAddr  <= i_baseAddr;
        wordCount <= i_numWords;
        index     <= '0;
        o_busy    <= 1'b1;
      end else if (state == DONE) begin
        o_busy <= 1'b0;
      end
`ifdef WB_TIMEOUT_EN
      else if (abortTimeout) begin
        o_busy <= 1'b0;
      end
`endif
      if (state == LATCH) begin
        o_dataToSdram <= i_dataFromRam;
        o_addrToSdram <= baseAddr + SDRAM_AW'(index);
      end
      if (ackTaken) begin
        index <= index + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_writeback_control.sv
// tb_writeback_control: randomized jobs against a queue-based model of the
// expected SDRAM write stream (addresses base+i mod 2^19, data RAM[i]).
// Build option WB_TIMEOUT_EN adds the withheld-acknowledge scenario.
module tb_writeback_control;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [18:0] i_baseAddr = '0;
  logic [12:0] i_numWords = '0;
  logic        o_rdRam;
  logic [11:0] o_addrToRam;
  logic [15:0] i_dataFromRam = '0;
  logic        o_wrSdram;
  logic [18:0] o_addrToSdram;
  logic [15:0] o_dataToSdram;
  logic        i_sdramReady = 1'b0;
  logic        o_busy;
  logic        o_finish;
`ifdef WB_TIMEOUT_EN
  logic        o_error;
  localparam int TIMEOUT = 1024;
`endif

  logic [15:0] ram [4096];
  int vecCnt = 0;
  int errCnt = 0;

  writeback_control dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_baseAddr    (i_baseAddr),
    .i_numWords    (i_numWords),
    .o_rdRam       (o_rdRam),
    .o_addrToRam   (o_addrToRam),
    .i_dataFromRam (i_dataFromRam),
    .o_wrSdram     (o_wrSdram),
    .o_addrToSdram (o_addrToSdram),
    .o_dataToSdram (o_dataToSdram),
    .i_sdramReady  (i_sdramReady),
    .o_busy        (o_busy),
    .o_finish      (o_finish)
`ifdef WB_TIMEOUT_EN
    ,
    .o_error       (o_error)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Synchronous-read result RAM.
  always @(posedge i_clk) begin
    if (o_rdRam) i_dataFromRam <= ram[o_addrToRam];
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outPack();
    return {13'b0, o_rdRam, o_wrSdram, o_busy, o_finish,
            o_addrToRam, o_addrToSdram, o_dataToSdram};
  endfunction

  // ackDelay < 0 withholds every acknowledge; abortAt > 0 resets the DUT
  // as soon as that write request appears.
  task automatic runJob(input logic [18:0] base, input int n, input int ackDelay,
                        input bit randAck, input int abortAt);
    logic [18:0] expAddr[$];
    logic [15:0] expData[$];
    logic [18:0] curA;
    logic [15:0] curD;
    int cyc, nWr, nRd, waitCnt, reqDelay, lastWrCyc, finishes, errSeen, budget;
    bit inWr, done;
    for (int i = 0; i < n; i++) begin
      ram[i] = 16'($urandom);
      expAddr.push_back(base + 19'(i));
      expData.push_back(ram[i]);
    end
    nWr = 0; nRd = 0; waitCnt = 0; reqDelay = 0; lastWrCyc = 0;
    finishes = 0; errSeen = 0; inWr = 0; done = 0; curA = '0; curD = '0;
    budget = 60 + n * 12 + 1100;
    @(negedge i_clk);
    i_start = 1'b1; i_baseAddr = base; i_numWords = 13'(n);
    @(negedge i_clk);
    i_start = 1'b0;
    cyc = 1;
    while (!done && cyc < budget) begin
      checkVal("rdWrExcl", 64'(o_rdRam & o_wrSdram), 0);
      if (cyc == 1) begin
        checkVal("busyOnStart", 64'(o_busy), 1);
        checkVal("firstRdT1", 64'(o_rdRam), 64'(n != 0));
      end
      if (cyc == 3) checkVal("firstWrT3", 64'(o_wrSdram), 64'(n != 0));
      if (o_rdRam) begin
        checkVal("ramAddr", 64'(o_addrToRam), 64'(nRd));
        nRd++;
      end
      if (o_wrSdram) begin
        if (!inWr) begin
          inWr = 1; waitCnt = 0; nWr++;
          checkVal("wrInRange", 64'(nWr <= n), 1);
          if (expAddr.size() > 0) begin
            checkVal("wrAddr", 64'(o_addrToSdram), 64'(expAddr.pop_front()));
            checkVal("wrData", 64'(o_dataToSdram), 64'(expData.pop_front()));
          end
          if (ackDelay == 0 && !randAck && nWr > 1)
            checkVal("zeroWaitRate", 64'(cyc - lastWrCyc), 3);
          lastWrCyc = cyc; curA = o_addrToSdram; curD = o_dataToSdram;
          reqDelay = randAck ? int'($urandom_range(0, 4)) : ackDelay;
          if (abortAt > 0 && nWr == abortAt) begin
            i_sdramReady = 1'b0;
            #2 i_reset = 1'b1;
            #1 checkVal("asyncRstOut", outPack(), 0);
            repeat (2) begin
              @(negedge i_clk);
              checkVal("rstHold", outPack(), 0);
            end
            i_reset = 1'b0;
            repeat (3) begin
              @(negedge i_clk);
              checkVal("postRstFinish", 64'(o_finish), 0);
              checkVal("postRstWr", 64'(o_wrSdram), 0);
            end
            return;
          end
        end else begin
          checkVal("addrHold", 64'(o_addrToSdram), 64'(curA));
          checkVal("dataHold", 64'(o_dataToSdram), 64'(curD));
        end
        i_sdramReady = (reqDelay >= 0) && (waitCnt == reqDelay);
        if (i_sdramReady) inWr = 0;
        waitCnt++;
      end else begin
        i_sdramReady = randAck && ($urandom_range(0, 3) == 0);
      end
      if (o_finish) begin
        finishes++;
        checkVal("finishQEmpty", 64'(expAddr.size()), 0);
        checkVal("busyAtFinish", 64'(o_busy), 0);
        if (n == 0) checkVal("zeroFinishT2", 64'(cyc), 2);
        i_start = 1'b1;
        done = 1;
      end
`ifdef WB_TIMEOUT_EN
      if (o_error) begin
        errSeen++;
        checkVal("errCycle", 64'(cyc), 64'(3 + TIMEOUT));
        checkVal("busyAtErr", 64'(o_busy), 0);
        checkVal("wrAtErr", 64'(o_wrSdram), 0);
        done = 1;
      end
`endif
      if (!done) begin
        @(negedge i_clk);
        cyc++;
      end
    end
    if (ackDelay < 0) checkVal("errorSeen", 64'(errSeen), 1);
    else              checkVal("finishSeen", 64'(finishes), 1);
    @(negedge i_clk);
    i_start = 1'b0;
    i_sdramReady = 1'b0;
    checkVal("startIgnored", 64'(o_busy), 0);
    checkVal("noRdAfter", 64'(o_rdRam), 0);
    repeat (2) begin
      @(negedge i_clk);
      checkVal("noExtraFinish", 64'(o_finish), 0);
    end
  endtask

  initial begin
    #1 checkVal("resetOut", outPack(), 0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (5) begin
      @(negedge i_clk);
      checkVal("idleOut", outPack(), 0);
    end

    runJob(19'd10000, 4, 3, 1'b0, 0);
    runJob(19'd777, 0, 0, 1'b0, 0);
    runJob(19'd524286, 3, 0, 1'b0, 0);
    runJob(19'd2000, 5, 2, 1'b0, 2);
    runJob(19'd300, 6, 1, 1'b0, 0);
    for (int j = 0; j < 8; j++)
      runJob(19'($urandom), int'($urandom_range(0, 20)), 0, 1'b1, 0);
`ifdef WB_TIMEOUT_EN
    runJob(19'd4242, 2, -1, 1'b0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
